// File: rtl/tag_array_ctrl_pkg.sv
// Shared constants and encodings for the L1 tag-array controller.
package tag_array_ctrl_pkg;

  localparam int unsigned TAG_SETS       = 64;
  localparam int unsigned TAG_IDX_W      = 6;
  localparam int unsigned TAG_WAYS       = 4;
  localparam int unsigned TAG_W          = 22;
  localparam int unsigned TAG_STARVE_MAX = 4;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_PRB = 1'b1
  } src_e;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

endpackage

// File: rtl/tag_arb_prio.sv
// Combinational one-hot grant for the shared tag SRAM port:
// refill > starved CPU > probe > CPU.
module tag_arb_prio (
  input  logic i_en,
  input  logic i_rfl_valid,
  input  logic i_prb_valid,
  input  logic i_cpu_valid,
  input  logic i_cpu_starved,
  output logic o_rfl_gnt,
  output logic o_prb_gnt,
  output logic o_cpu_gnt
);

  always_comb begin
    o_rfl_gnt = 1'b0;
    o_prb_gnt = 1'b0;
    o_cpu_gnt = 1'b0;
    if (i_en) begin
      if (i_rfl_valid)                      o_rfl_gnt = 1'b1;
      else if (i_cpu_valid && i_cpu_starved) o_cpu_gnt = 1'b1;
      else if (i_prb_valid)                 o_prb_gnt = 1'b1;
      else if (i_cpu_valid)                 o_cpu_gnt = 1'b1;
    end
  end

endmodule

// File: rtl/tag_array_ctrl.sv
// Sequencer/arbiter in front of the single-port L1 tag SRAM: invalidation walk
// after reset, then refill/probe/CPU sharing. Optional TAG_ARRAY_CTRL_FLUSH_CMD_EN adds flush_req.
module tag_array_ctrl #(
  parameter int unsigned SETS       = tag_array_ctrl_pkg::TAG_SETS,
  parameter int unsigned IDX_W      = tag_array_ctrl_pkg::TAG_IDX_W,
  parameter int unsigned WAYS       = tag_array_ctrl_pkg::TAG_WAYS,
  parameter int unsigned TAG_W      = tag_array_ctrl_pkg::TAG_W,
  parameter int unsigned STARVE_MAX = tag_array_ctrl_pkg::TAG_STARVE_MAX
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef TAG_ARRAY_CTRL_FLUSH_CMD_EN
  input  logic                  flush_req,
`endif
  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  input  logic [IDX_W-1:0]      cpu_idx,
  input  logic                  prb_valid,
  output logic                  prb_ready,
  input  logic [IDX_W-1:0]      prb_idx,
  input  logic                  rfl_valid,
  output logic                  rfl_ready,
  input  logic [IDX_W-1:0]      rfl_idx,
  input  logic [WAYS-1:0]       rfl_wmask,
  input  logic [WAYS*TAG_W-1:0] rfl_wdata,
  output logic                  resp_valid,
  output logic                  resp_src,
  output logic [WAYS*TAG_W-1:0] resp_rdata,
  output logic                  flush_busy,
  output logic [IDX_W-1:0]      sram_addr,
  output logic                  sram_en,
  output logic                  sram_wmode,
  output logic [WAYS*TAG_W-1:0] sram_wdata,
  output logic [WAYS-1:0]       sram_wmask,
  input  logic [WAYS*TAG_W-1:0] sram_rdata
);

  import tag_array_ctrl_pkg::*;

  localparam int unsigned STW = $clog2(STARVE_MAX + 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [IDX_W-1:0] r_flush_cnt;
  logic [STW-1:0]   r_starve;
  logic             r_resp_valid;
  src_e             r_src;
  logic             w_starved;
  logic             w_serve;
  logic             w_flush_cmd;
  logic             w_rfl_gnt;
  logic             w_prb_gnt;
  logic             w_cpu_gnt;
  logic             w_rd_gnt;

`ifdef TAG_ARRAY_CTRL_FLUSH_CMD_EN
  assign w_flush_cmd = flush_req;
`else
  assign w_flush_cmd = 1'b0;
`endif

  assign w_serve   = (r_state == ST_SERVE);
  assign w_starved = (r_starve >= STW'(STARVE_MAX));
  assign w_rd_gnt  = w_prb_gnt | w_cpu_gnt;

  tag_arb_prio u_arb (
    .i_en          (w_serve),
    .i_rfl_valid   (rfl_valid),
    .i_prb_valid   (prb_valid),
    .i_cpu_valid   (cpu_valid),
    .i_cpu_starved (w_starved),
    .o_rfl_gnt     (w_rfl_gnt),
    .o_prb_gnt     (w_prb_gnt),
    .o_cpu_gnt     (w_cpu_gnt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_FLUSH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FLUSH: if (r_flush_cnt == IDX_W'(SETS - 1)) w_next_state = ST_SERVE;
      ST_SERVE: if (w_flush_cmd) w_next_state = ST_FLUSH;
      default:  w_next_state = ST_FLUSH;
    endcase
  end

  // Counter rests at 0 while serving so any re-entry into FLUSH starts at set 0.
  // Starvation only accrues while serving; a walk leaves it cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flush_cnt  <= '0;
      r_starve     <= '0;
      r_resp_valid <= 1'b0;
      r_src        <= SRC_CPU;
    end else begin
      if (r_state == ST_FLUSH) r_flush_cnt <= r_flush_cnt + 1'b1;
      else                     r_flush_cnt <= '0;
      if (w_serve && cpu_valid && !w_cpu_gnt) begin
        if (!w_starved) r_starve <= r_starve + 1'b1;
      end else begin
        r_starve <= '0;
      end
      r_resp_valid <= w_rd_gnt;
      if (w_rd_gnt) r_src <= w_prb_gnt ? SRC_PRB : SRC_CPU;
    end
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    if (r_state == ST_FLUSH) begin
      sram_en    = !reset;
      sram_wmode = 1'b1;
      sram_addr  = r_flush_cnt;
      sram_wmask = '1;
    end else if (w_rfl_gnt) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = rfl_idx;
      sram_wdata = rfl_wdata;
      sram_wmask = rfl_wmask;
    end else if (w_prb_gnt) begin
      sram_en    = 1'b1;
      sram_addr  = prb_idx;
    end else if (w_cpu_gnt) begin
      sram_en    = 1'b1;
      sram_addr  = cpu_idx;
    end
  end

  assign rfl_ready  = w_rfl_gnt;
  assign prb_ready  = w_prb_gnt;
  assign cpu_ready  = w_cpu_gnt;
  assign flush_busy = (r_state == ST_FLUSH);
  assign resp_valid = r_resp_valid;
  assign resp_src   = r_src;
  assign resp_rdata = sram_rdata;

endmodule

// File: tb/tb_tag_array_ctrl.sv
// Self-checking bench for tag_array_ctrl: behavioural SRAM plus a reference
// model of flush walk, arbitration, starvation and read responses.
module tb_tag_array_ctrl;

  localparam int SETS       = 64;
  localparam int WAYS       = 4;
  localparam int TW         = 22;
  localparam int STARVE_MAX = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush_req = 1'b0;
  logic        cpu_valid = 1'b0, prb_valid = 1'b0, rfl_valid = 1'b0;
  logic        cpu_ready, prb_ready, rfl_ready;
  logic [5:0]  cpu_idx = '0, prb_idx = '0, rfl_idx = '0;
  logic [3:0]  rfl_wmask = '0;
  logic [87:0] rfl_wdata = '0;
  logic        resp_valid, resp_src, flush_busy;
  logic [87:0] resp_rdata;
  logic [5:0]  sram_addr;
  logic        sram_en, sram_wmode;
  logic [87:0] sram_wdata;
  logic [3:0]  sram_wmask;
  logic [87:0] sram_rdata;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  tag_array_ctrl dut (
    .clock      (clock),
    .reset      (reset),
`ifdef TAG_ARRAY_CTRL_FLUSH_CMD_EN
    .flush_req  (flush_req),
`endif
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .cpu_idx    (cpu_idx),
    .prb_valid  (prb_valid),
    .prb_ready  (prb_ready),
    .prb_idx    (prb_idx),
    .rfl_valid  (rfl_valid),
    .rfl_ready  (rfl_ready),
    .rfl_idx    (rfl_idx),
    .rfl_wmask  (rfl_wmask),
    .rfl_wdata  (rfl_wdata),
    .resp_valid (resp_valid),
    .resp_src   (resp_src),
    .resp_rdata (resp_rdata),
    .flush_busy (flush_busy),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_wdata (sram_wdata),
    .sram_wmask (sram_wmask),
    .sram_rdata (sram_rdata)
  );

  // Single-port SRAM: masked write, read data registered one cycle later.
  logic [87:0] mem [SETS];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int w = 0; w < WAYS; w++)
          if (sram_wmask[w]) mem[sram_addr][w*TW +: TW] <= sram_wdata[w*TW +: TW];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  // Reference model state
  logic [87:0] ref_tags [SETS];
  bit          m_flush;
  int          m_fcnt;
  int          m_starve;
  bit          m_rv;
  bit          m_rsrc;
  logic [87:0] m_rdata;

  task automatic chk(input string tag, input logic [87:0] got, input logic [87:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_flush  = 1'b1;
    m_fcnt   = 0;
    m_starve = 0;
    m_rv     = 1'b0;
    m_rsrc   = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_flush_busy", flush_busy, 1'b1);
    chk("rst_readies", {rfl_ready, prb_ready, cpu_ready}, 3'b000);
    chk("rst_sram_en", sram_en, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_src", resp_src, 1'b0);
  endtask

  // Called at a negedge; drives one cycle, checks, advances the model, ends at next negedge.
  task automatic step(input logic rv, input logic [5:0] ri, input logic [3:0] rm,
                      input logic [87:0] rd, input logic pv, input logic [5:0] pi,
                      input logic cv, input logic [5:0] ci, input logic fr);
    bit gr, gp, gc;
    rfl_valid = rv; rfl_idx = ri; rfl_wmask = rm; rfl_wdata = rd;
    prb_valid = pv; prb_idx = pi; cpu_valid = cv; cpu_idx = ci;
    flush_req = fr;
    gr = 1'b0; gp = 1'b0; gc = 1'b0;
    if (!m_flush) begin
      if (rv) gr = 1'b1;
      else if (cv && (m_starve >= STARVE_MAX || !pv)) gc = 1'b1;
      else if (pv) gp = 1'b1;
    end
    #1;
    chk("flush_busy", flush_busy, m_flush);
    chk("readies", {rfl_ready, prb_ready, cpu_ready}, {gr, gp, gc});
    chk("sram_en", sram_en, m_flush | gr | gp | gc);
    if (m_flush) begin
      chk("flush_addr", sram_addr, m_fcnt[5:0]);
      chk("flush_wmode", sram_wmode, 1'b1);
      chk("flush_wmask", sram_wmask, 4'hF);
      chk("flush_wdata", sram_wdata, '0);
    end else if (gr) begin
      chk("rfl_addr", sram_addr, ri);
      chk("rfl_wmode", sram_wmode, 1'b1);
      chk("rfl_wmask", sram_wmask, rm);
      chk("rfl_wdata", sram_wdata, rd);
    end else if (gp || gc) begin
      chk("rd_addr", sram_addr, gp ? pi : ci);
      chk("rd_wmode", sram_wmode, 1'b0);
      chk("rd_wmask", sram_wmask, 4'h0);
    end
    chk("resp_valid", resp_valid, m_rv);
    if (m_rv) begin
      chk("resp_src", resp_src, m_rsrc);
      chk("resp_rdata", resp_rdata, m_rdata);
    end
    m_rv = gp | gc;
    if (gp || gc) begin
      m_rsrc  = gp;
      m_rdata = ref_tags[gp ? pi : ci];
    end
    if (m_flush) begin
      ref_tags[m_fcnt] = '0;
      m_starve = 0;
      if (m_fcnt == SETS - 1) begin
        m_flush = 1'b0;
        m_fcnt  = 0;
      end else begin
        m_fcnt++;
      end
    end else begin
      if (gr)
        for (int w = 0; w < WAYS; w++)
          if (rm[w]) ref_tags[ri][w*TW +: TW] = rd[w*TW +: TW];
      if (cv && !gc) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else           m_starve = 0;
`ifdef TAG_ARRAY_CTRL_FLUSH_CMD_EN
      if (fr) begin
        m_flush = 1'b1;
        m_fcnt  = 0;
      end
`endif
    end
    @(negedge clock);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic step_rand(input int flush_odds);
    logic [95:0] r96;
    logic        rv, pv, cv, fr;
    r96 = {$urandom(), $urandom(), $urandom()};
    rv  = ($urandom_range(0, 3) == 0);
    pv  = $urandom_range(0, 1) == 1;
    cv  = $urandom_range(0, 1) == 1;
    fr  = (flush_odds > 0) && ($urandom_range(1, flush_odds) == 1);
    step(rv, 6'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), r96[87:0],
         pv, 6'($urandom_range(0, 7)), cv, 6'($urandom_range(0, 7)), fr);
  endtask

  // Asserted between edges, held across one posedge, released at a negedge.
  task automatic reset_midcycle();
    #2 reset = 1'b1;
    #1 check_reset_state();
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [87:0] d;
    model_reset();
    @(negedge clock);
    #1 check_reset_state();
    @(negedge clock);
    reset = 1'b0;

    // Walk with requests present; they must be ignored.
    for (int i = 0; i < SETS; i++) step_rand(0);
    idle();

    d = '0;
    d[2*TW +: TW] = 22'h2ABCDE;
    step(1'b1, 6'd5, 4'b0100, d, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 6'd5, 1'b0);
    idle();
    chk("dir_way2_tag", d[2*TW +: TW], ref_tags[5][2*TW +: TW]);

    // All three valid, then probe and CPU hold until served.
    step(1'b1, 6'd6, 4'hF, {4{22'h155555}}, 1'b1, 6'd5, 1'b1, 6'd6, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 6'd5, 1'b1, 6'd6, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 6'd6, 1'b0);
    idle();

    // Continuous probe + CPU pressure: starvation promotion pattern.
    for (int i = 0; i < 16; i++)
      step(1'b0, '0, '0, '0, 1'b1, 6'(i % 8), 1'b1, 6'((i + 3) % 8), 1'b0);
    idle();

    for (int i = 0; i < 400; i++) step_rand(0);
    idle();

    // Reset in the middle of a walk restarts it from set 0.
    reset_midcycle();
    for (int i = 0; i < 30; i++) step_rand(0);
    reset_midcycle();
    for (int i = 0; i < SETS + 2; i++) step_rand(0);

`ifdef TAG_ARRAY_CTRL_FLUSH_CMD_EN
    idle();
    step(1'b1, 6'd9, 4'hF, {4{22'h3FFFFF}}, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 6'd9, 1'b1);
    for (int i = 0; i < SETS; i++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 6'd9, 1'b0);
    idle();
    for (int i = 0; i < 300; i++) step_rand(60);
`endif
    for (int i = 0; i < 100; i++) step_rand(0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
